// File: rtl/cgra_mem_arb_pkg.sv
// Shared types and width helpers for the CGRA SRAM bank arbiter.
package cgra_mem_arb_pkg;

  localparam int unsigned DataWidth = 32;
  localparam int unsigned BeWidth   = 4;

  // Retention controller states
  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    RET    = 2'd1,
    WAKE   = 2'd2
  } ret_state_e;

  // Write-side payload forwarded from the granted port to the bank
  typedef struct packed {
    logic                 we;
    logic [DataWidth-1:0] wdata;
    logic [BeWidth-1:0]   be;
  } mem_payload_t;

  // Idle counter width; must be able to hold idle_cycles itself
  function automatic int unsigned cnt_width(input int unsigned idle_cycles);
    return (idle_cycles == 0) ? 1 : $clog2(idle_cycles + 1);
  endfunction

  // Word address width, at least one bit
  function automatic int unsigned addr_width(input int unsigned num_words);
    return (num_words <= 2) ? 1 : $clog2(num_words);
  endfunction

endpackage

// File: rtl/cgra_mem_rr_arb.sv
// Round-robin arbiter: one-hot grant starting at the pointer, pointer moves past the winner.
module cgra_mem_rr_arb
  import cgra_mem_arb_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 4,
  localparam int unsigned IdxWidth = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NUM_PORTS-1:0] req,
  input  logic                 enable,
  output logic [NUM_PORTS-1:0] gnt,
  output logic [IdxWidth-1:0]  gnt_idx
);

  logic [IdxWidth-1:0] ptr_q;
  logic [IdxWidth-1:0] ptr_d;
  logic [31:0]         cand;
  logic                found;

  // Search upward from the pointer, modulo NUM_PORTS, for the first requester
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (!found) begin
        cand = 32'(ptr_q) + i;
        if (cand >= NUM_PORTS) begin
          cand = cand - NUM_PORTS;
        end
        if (enable && req[IdxWidth'(cand)]) begin
          found                  = 1'b1;
          gnt[IdxWidth'(cand)]   = 1'b1;
          gnt_idx                = IdxWidth'(cand);
        end
      end
    end
  end

  // Next pointer sits just past the winner, wrapping to port 0
  always_comb begin
    ptr_d = ptr_q;
    if (found) begin
      ptr_d = (32'(gnt_idx) == NUM_PORTS - 1) ? '0 : gnt_idx + 1'b1;
    end
  end

  // Pointer register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/cgra_mem_arbiter.sv
// Shares one single-port CGRA SRAM bank between NUM_PORTS requesters.
// Optional idle-driven retention control is built when CGRA_MEM_ARB_RET_EN is defined.
module cgra_mem_arbiter
  import cgra_mem_arb_pkg::*;
#(
  parameter int unsigned NUM_PORTS   = 4,
  parameter int unsigned NUM_WORDS   = 1024,
  parameter int unsigned IDLE_CYCLES = 16,
  localparam int unsigned AddrWidth  = addr_width(NUM_WORDS)
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NUM_PORTS-1:0]           req_i,
  input  logic [NUM_PORTS-1:0]           we_i,
  input  logic [NUM_PORTS*AddrWidth-1:0] addr_i,
  input  logic [NUM_PORTS*DataWidth-1:0] wdata_i,
  input  logic [NUM_PORTS*BeWidth-1:0]   be_i,
  output logic [NUM_PORTS-1:0]           gnt_o,
  output logic [NUM_PORTS-1:0]           rvalid_o,
  output logic [NUM_PORTS*DataWidth-1:0] rdata_o,
  output logic                           mem_req_o,
  output logic                           mem_we_o,
  output logic [AddrWidth-1:0]           mem_addr_o,
  output logic [DataWidth-1:0]           mem_wdata_o,
  output logic [BeWidth-1:0]             mem_be_o,
  output logic                           mem_set_retentive_no,
  input  logic [DataWidth-1:0]           mem_rdata_i
);

  localparam int unsigned IdxWidth = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic                 arb_en;
  logic [IdxWidth-1:0]  gnt_idx;
  logic [NUM_PORTS-1:0] rvalid_q;
  mem_payload_t         payload;

  cgra_mem_rr_arb #(
    .NUM_PORTS (NUM_PORTS)
  ) u_arb (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .req     (req_i),
    .enable  (arb_en),
    .gnt     (gnt_o),
    .gnt_idx (gnt_idx)
  );

  // Route the granted port's transaction to the bank
  always_comb begin
    payload     = '0;
    mem_req_o   = |gnt_o;
    mem_addr_o  = '0;
    if (mem_req_o) begin
      payload.we    = we_i[gnt_idx];
      payload.wdata = wdata_i[32'(gnt_idx)*DataWidth +: DataWidth];
      payload.be    = be_i[32'(gnt_idx)*BeWidth +: BeWidth];
      mem_addr_o    = addr_i[32'(gnt_idx)*AddrWidth +: AddrWidth];
    end
    mem_we_o    = payload.we;
    mem_wdata_o = payload.wdata;
    mem_be_o    = payload.be;
  end

  // Remember which port owns the response arriving next cycle
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_q <= '0;
    end else begin
      rvalid_q <= gnt_o;
    end
  end

  assign rvalid_o = rvalid_q;

  // Steer bank read data only to the port whose response is valid
  always_comb begin
    rdata_o = '0;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      if (rvalid_q[k]) begin
        rdata_o[k*DataWidth +: DataWidth] = mem_rdata_i;
      end
    end
  end

`ifdef CGRA_MEM_ARB_RET_EN
  localparam int unsigned CntWidth = cnt_width(IDLE_CYCLES);

  ret_state_e          state_q;
  ret_state_e          state_d;
  logic [CntWidth-1:0] cnt_q;
  logic [CntWidth-1:0] cnt_d;
  logic                idle;

  assign idle = ~|req_i;

  // Retention FSM: count idle cycles, sleep at threshold, one-cycle wake on any request
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ACTIVE: begin
        if (!idle) begin
          cnt_d = '0;
        end else if (IDLE_CYCLES != 0) begin
          if (32'(cnt_q) + 32'd1 >= IDLE_CYCLES) begin
            state_d = RET;
            cnt_d   = CntWidth'(IDLE_CYCLES);
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      RET: begin
        if (!idle) begin
          state_d = WAKE;
        end
      end
      WAKE: begin
        state_d = ACTIVE;
        cnt_d   = '0;
      end
      default: begin
        state_d = ACTIVE;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM and idle counter registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ACTIVE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign arb_en               = (state_q == ACTIVE);
  assign mem_set_retentive_no = (state_q != RET);
`else
  assign arb_en               = 1'b1;
  assign mem_set_retentive_no = 1'b1;
`endif

endmodule

// File: tb/tb_cgra_mem_arbiter.sv
// Randomized + directed bench for cgra_mem_arbiter with a transaction-level reference model.
module tb_cgra_mem_arbiter;

  localparam int unsigned NP   = 4;
  localparam int unsigned NW   = 64;
  localparam int unsigned AW   = 6;
  localparam int unsigned IDLE = 16;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic [NP-1:0]     req_i, we_i;
  logic [NP*AW-1:0]  addr_i;
  logic [NP*32-1:0]  wdata_i;
  logic [NP*4-1:0]   be_i;
  logic [NP-1:0]     gnt_o, rvalid_o;
  logic [NP*32-1:0]  rdata_o;
  logic              mem_req_o, mem_we_o, mem_set_retentive_no;
  logic [AW-1:0]     mem_addr_o;
  logic [31:0]       mem_wdata_o, mem_rdata_i;
  logic [3:0]        mem_be_o;

  int total = 0;
  int bad   = 0;

  cgra_mem_arbiter #(
    .NUM_PORTS   (NP),
    .NUM_WORDS   (NW),
    .IDLE_CYCLES (IDLE)
  ) dut (
    .clk_i                (clk_i),
    .rst_ni               (rst_ni),
    .req_i                (req_i),
    .we_i                 (we_i),
    .addr_i               (addr_i),
    .wdata_i              (wdata_i),
    .be_i                 (be_i),
    .gnt_o                (gnt_o),
    .rvalid_o             (rvalid_o),
    .rdata_o              (rdata_o),
    .mem_req_o            (mem_req_o),
    .mem_we_o             (mem_we_o),
    .mem_addr_o           (mem_addr_o),
    .mem_wdata_o          (mem_wdata_o),
    .mem_be_o             (mem_be_o),
    .mem_set_retentive_no (mem_set_retentive_no),
    .mem_rdata_i          (mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  // Behavioural SRAM bank: 1-cycle read latency, byte-enabled writes
  logic [31:0] sram [NW];
  logic [31:0] sram_w;
  always @(posedge clk_i) begin
    if (mem_req_o) begin
      if (mem_we_o) begin
        sram_w = sram[mem_addr_o];
        for (int b = 0; b < 4; b++) if (mem_be_o[b]) sram_w[8*b +: 8] = mem_wdata_o[8*b +: 8];
        sram[mem_addr_o] <= sram_w;
      end else begin
        mem_rdata_i <= sram[mem_addr_o];
      end
    end
  end

  // Per-port pending request
  logic          p_req  [NP];
  logic          p_we   [NP];
  logic [AW-1:0] p_addr [NP];
  logic [31:0]   p_wdata[NP];
  logic [3:0]    p_be   [NP];

  // Reference model state
  int          m_ptr;
  bit          m_pv;
  int          m_pport;
  bit          m_pread;
  logic [31:0] m_pdata;
  bit          m_ret, m_wake;
  int          m_idle;
  logic [31:0] ref_mem [NW];

  // Last observed DUT values, for hand-computed literal checks
  logic [NP-1:0]    obs_gnt, obs_rvalid;
  logic [NP*32-1:0] obs_rdata;
  logic             obs_ret;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic apply();
    for (int k = 0; k < NP; k++) begin
      req_i[k]            = p_req[k];
      we_i[k]             = p_we[k];
      addr_i[k*AW +: AW]  = p_addr[k];
      wdata_i[k*32 +: 32] = p_wdata[k];
      be_i[k*4 +: 4]      = p_be[k];
    end
  endtask

  task automatic set_req(input int k, input logic we, input logic [AW-1:0] a,
                         input logic [31:0] d, input logic [3:0] be);
    p_req[k] = 1'b1; p_we[k] = we; p_addr[k] = a; p_wdata[k] = d; p_be[k] = be;
  endtask

  task automatic clear_reqs();
    for (int k = 0; k < NP; k++) begin
      p_req[k] = 1'b0; p_we[k] = 1'b0; p_addr[k] = '0; p_wdata[k] = '0; p_be[k] = '0;
    end
    apply();
  endtask

  task automatic model_reset();
    m_ptr = 0; m_pv = 0; m_pport = 0; m_pread = 0; m_pdata = '0;
    m_ret = 0; m_wake = 0; m_idle = 0;
  endtask

  // One clock cycle: check DUT against the model mid-cycle, then advance the model at the edge
  task automatic cycle();
    logic [NP-1:0] eg, erv;
    int  gk;
    bit  en, any_req;
    @(negedge clk_i);
    en = !(m_ret || m_wake);
    any_req = 0;
    for (int k = 0; k < NP; k++) if (p_req[k]) any_req = 1;
    gk = -1;
    if (en) begin
      for (int i = 0; i < NP; i++) begin
        int c;
        c = (m_ptr + i) % NP;
        if (gk < 0 && p_req[c]) gk = c;
      end
    end
    eg = '0;
    if (gk >= 0) eg[gk] = 1'b1;
    chk("gnt", gnt_o, eg);
    chk("mem_req", mem_req_o, 1'(gk >= 0));
    if (gk >= 0) begin
      chk("mem_we", mem_we_o, p_we[gk]);
      chk("mem_addr", mem_addr_o, p_addr[gk]);
      if (p_we[gk]) begin
        chk("mem_wdata", mem_wdata_o, p_wdata[gk]);
        chk("mem_be", mem_be_o, p_be[gk]);
      end
    end
    erv = '0;
    if (m_pv) erv[m_pport] = 1'b1;
    chk("rvalid", rvalid_o, erv);
    for (int k = 0; k < NP; k++) begin
      if (!erv[k]) chk($sformatf("rdata_idle%0d", k), rdata_o[k*32 +: 32], 32'h0);
      else if (m_pread) chk($sformatf("rdata%0d", k), rdata_o[k*32 +: 32], m_pdata);
    end
    chk("ret_n", mem_set_retentive_no, !m_ret);
    obs_gnt = gnt_o; obs_rvalid = rvalid_o; obs_rdata = rdata_o; obs_ret = mem_set_retentive_no;
    @(posedge clk_i);
    m_pv = (gk >= 0);
    if (gk >= 0) begin
      m_pport = gk;
      m_pread = !p_we[gk];
      if (p_we[gk]) begin
        for (int b = 0; b < 4; b++)
          if (p_be[gk][b]) ref_mem[p_addr[gk]][8*b +: 8] = p_wdata[gk][8*b +: 8];
      end else begin
        m_pdata = ref_mem[p_addr[gk]];
      end
      m_ptr = (gk + 1) % NP;
      p_req[gk] = 1'b0;
    end
`ifdef CGRA_MEM_ARB_RET_EN
    if (m_wake) begin
      m_wake = 0; m_idle = 0;
    end else if (m_ret) begin
      if (any_req) begin m_ret = 0; m_wake = 1; end
    end else if (any_req) begin
      m_idle = 0;
    end else begin
      m_idle++;
      if (IDLE != 0 && m_idle >= IDLE) begin m_ret = 1; m_idle = 0; end
    end
`endif
    #1;
    apply();
  endtask

  task automatic hold_and_release();
    model_reset();
    clear_reqs();
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < NW; i++) begin sram[i] = '0; ref_mem[i] = '0; end
    mem_rdata_i = '0;
    rst_ni = 1'b0;
    clear_reqs();
    model_reset();

    // Reset values
    repeat (2) @(negedge clk_i);
    chk("rst_gnt", gnt_o, 4'h0);
    chk("rst_rvalid", rvalid_o, 4'h0);
    chk("rst_rdata", rdata_o, 128'h0);
    chk("rst_mem_req", mem_req_o, 1'b0);
    chk("rst_mem_we", mem_we_o, 1'b0);
    chk("rst_ret_n", mem_set_retentive_no, 1'b1);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;

    // Ports 0 and 2 writing continuously: grants alternate
    set_req(0, 1'b1, 6'h10, 32'hA000_0000, 4'hF);
    set_req(2, 1'b1, 6'h20, 32'hB000_0000, 4'hF);
    apply();
    for (int i = 0; i < 6; i++) begin
      cycle();
      chk("alt_seq", obs_gnt, (i % 2 == 0) ? 4'b0001 : 4'b0100);
      if (i < 4) begin
        if (i % 2 == 0) set_req(0, 1'b1, 6'h10, 32'hA000_0000 + 32'(i / 2 + 1), 4'hF);
        else            set_req(2, 1'b1, 6'h20, 32'hB000_0000 + 32'(i / 2 + 1), 4'hF);
        apply();
      end
    end
    set_req(0, 1'b0, 6'h10, 32'h0, 4'h0);
    set_req(2, 1'b0, 6'h20, 32'h0, 4'h0);
    apply();
    cycle();
    chk("rb_gnt0", obs_gnt, 4'b0001);
    cycle();
    chk("rb_rdata0", obs_rdata[31:0], 32'hA000_0002);
    cycle();
    chk("rb_rdata2", obs_rdata[95:64], 32'hB000_0002);

    // Byte-enable merge on port 1
    set_req(1, 1'b1, 6'd5, 32'h1111_1111, 4'hF); apply(); cycle();
    set_req(1, 1'b1, 6'd5, 32'hDEAD_BEEF, 4'b0101); apply(); cycle();
    set_req(1, 1'b0, 6'd5, 32'h0, 4'h0); apply(); cycle();
    cycle();
    chk("be_rvalid", obs_rvalid, 4'b0010);
    chk("be_rdata", obs_rdata, {32'h0, 32'h0, 32'h11AD_11EF, 32'h0});

    // Pointer at 3, all ports request: wrap-around order 3,0,1,2
    set_req(2, 1'b0, 6'd2, 32'h0, 4'h0); apply(); cycle();
    for (int k = 0; k < NP; k++) set_req(k, 1'b0, AW'(k), 32'h0, 4'h0);
    apply();
    cycle(); chk("wrap3", obs_gnt, 4'b1000);
    cycle(); chk("wrap0", obs_gnt, 4'b0001);
    cycle(); chk("wrap1", obs_gnt, 4'b0010);
    cycle(); chk("wrap2", obs_gnt, 4'b0100);

`ifdef CGRA_MEM_ARB_RET_EN
    // 16 idle cycles then retention; request then wakes with 2-cycle penalty
    for (int i = 0; i < 16; i++) begin cycle(); chk("idle_awake", obs_ret, 1'b1); end
    cycle(); chk("ret_enter", obs_ret, 1'b0);
    set_req(2, 1'b0, 6'd7, 32'h0, 4'h0); apply();
    cycle(); chk("ret_req_ret", obs_ret, 1'b0); chk("ret_req_gnt", obs_gnt, 4'h0);
    cycle(); chk("wake_ret", obs_ret, 1'b1); chk("wake_gnt", obs_gnt, 4'h0);
    cycle(); chk("wake_grant", obs_gnt, 4'b0100);

    // Request in the threshold cycle keeps the bank awake and restarts the count
    for (int i = 0; i < 15; i++) cycle();
    set_req(0, 1'b1, 6'd9, 32'h1234_5678, 4'hF); apply();
    cycle(); chk("thr_gnt", obs_gnt, 4'b0001); chk("thr_ret", obs_ret, 1'b1);
    for (int i = 0; i < 16; i++) cycle();
    chk("thr_restart", obs_ret, 1'b1);
    cycle(); chk("thr_ret_late", obs_ret, 1'b0);

    // Request withdrawn while retained: wake still completes, nothing granted
    set_req(3, 1'b0, 6'd3, 32'h0, 4'h0); apply();
    cycle();
    p_req[3] = 1'b0; apply();
    cycle(); chk("wd_wake_ret", obs_ret, 1'b1); chk("wd_wake_gnt", obs_gnt, 4'h0);
    cycle(); chk("wd_active", obs_ret, 1'b1);

    // Reset while retained releases retention asynchronously
    repeat (17) cycle();
    chk("ret_again", obs_ret, 1'b0);
    rst_ni = 1'b0; #1;
    chk("rst_ret_release", mem_set_retentive_no, 1'b1);
    hold_and_release();
`else
    // Without retention support the bank never sleeps
    repeat (20) cycle();
    chk("noret_ret", obs_ret, 1'b1);
    set_req(2, 1'b0, 6'd7, 32'h0, 4'h0); apply();
    cycle(); chk("noret_gnt", obs_gnt, 4'b0100);
`endif

    // Reset in the cycle after a read grant drops the response
    set_req(1, 1'b0, 6'd5, 32'h0, 4'h0); apply();
    cycle();
    clear_reqs();
    rst_ni = 1'b0; #1;
    chk("rst_mid_rvalid", rvalid_o, 4'h0);
    chk("rst_mid_rdata", rdata_o, 128'h0);
    chk("rst_mid_ret", mem_set_retentive_no, 1'b1);
    hold_and_release();
    set_req(0, 1'b0, 6'd5, 32'h0, 4'h0); apply();
    cycle(); chk("post_rst_gnt", obs_gnt, 4'b0001);
    cycle(); chk("post_rst_rdata", obs_rdata[31:0], 32'h11AD_11EF);

    // Randomized traffic with occasional idle stretches
    begin
      int quiet;
      quiet = 0;
      for (int n = 0; n < 2000; n++) begin
        if (quiet > 0) quiet--;
        else if ($urandom_range(59) == 0) quiet = $urandom_range(25, 5);
        for (int k = 0; k < NP; k++) begin
          if (!p_req[k] && quiet == 0 && $urandom_range(2) == 0)
            set_req(k, 1'($urandom_range(1)), AW'($urandom_range(NW - 1)), $urandom, 4'($urandom_range(15)));
        end
        apply();
        cycle();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
